// File: rtl/time_counter.sv
// Stopwatch time base: divides the clock down to a one-second tick and keeps a
// binary minutes:seconds count that wraps from 59:59 to 00:00.
module time_counter #(
  parameter int unsigned TICKS_PER_SECOND = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hold_clock,
  output logic [5:0] minutes,
  output logic [5:0] seconds
);

  localparam int unsigned PW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [PW-1:0] PMax = PW'(TICKS_PER_SECOND - 1);

  logic [PW-1:0] p_q, p_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic          tick;

  always_comb begin
    p_d   = p_q;
    sec_d = sec_q;
    min_d = min_q;
    tick  = 1'b0;
    // Holding freezes the prescaler too, so the partial second survives.
    if (!hold_clock) begin
      if (p_q == PMax) begin
        p_d  = '0;
        tick = 1'b1;
      end else begin
        p_d = p_q + PW'(1);
      end
    end
    if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_q   <= '0;
      sec_q <= 6'd0;
      min_q <= 6'd0;
    end else begin
      p_q   <= p_d;
      sec_q <= sec_d;
      min_q <= min_d;
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: two instances (1 and 4 ticks per second)
// share stimulus and are compared against an unheld-edge-count reference model.
module tb_time_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       hold_clock = 1'b0;
  logic [5:0] minutes1, seconds1, minutes4, seconds4;

  int checks = 0;
  int errors = 0;

  // Reference: time is simply the number of unheld edges since reset, divided down.
  int cnt1 = 0;
  int cnt4 = 0;

  time_counter #(.TICKS_PER_SECOND(1)) dut1 (
    .clock      (clock),
    .reset      (reset),
    .hold_clock (hold_clock),
    .minutes    (minutes1),
    .seconds    (seconds1)
  );

  time_counter #(.TICKS_PER_SECOND(4)) dut4 (
    .clock      (clock),
    .reset      (reset),
    .hold_clock (hold_clock),
    .minutes    (minutes4),
    .seconds    (seconds4)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt1 <= 0;
      cnt4 <= 0;
    end else if (!hold_clock) begin
      cnt1 <= cnt1 + 1;
      cnt4 <= cnt4 + 1;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " t1 min"}, int'(minutes1), (cnt1 / 60) % 60);
    check({tag, " t1 sec"}, int'(seconds1), cnt1 % 60);
    check({tag, " t4 min"}, int'(minutes4), (cnt4 / 4 / 60) % 60);
    check({tag, " t4 sec"}, int'(seconds4), (cnt4 / 4) % 60);
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check("reset pulse t1 min", int'(minutes1), 0);
    check("reset pulse t1 sec", int'(seconds1), 0);
    check("reset pulse t4 min", int'(minutes4), 0);
    check("reset pulse t4 sec", int'(seconds4), 0);
    reset = 1'b1;
  endtask

  typedef struct {
    bit rst_first;
    bit hold;
    int n;
    int exp_min;
    int exp_sec;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 125, 2, 5};
    vecs[1] = '{1'b1, 1'b0, 30, 0, 30};
    vecs[2] = '{1'b0, 1'b1, 50, 0, 30};
    vecs[3] = '{1'b0, 1'b0, 10, 0, 40};
    vecs[4] = '{1'b1, 1'b0, 3599, 59, 59};
    vecs[5] = '{1'b0, 1'b0, 1, 0, 0};
    vecs[6] = '{1'b0, 1'b0, 1, 0, 1};

    // Reset held for 10 edges.
    reset = 1'b0;
    hold_clock = 1'b0;
    edges(10);
    check("reset t1 min", int'(minutes1), 0);
    check("reset t1 sec", int'(seconds1), 0);
    check("reset t4 min", int'(minutes4), 0);
    check("reset t4 sec", int'(seconds4), 0);
    reset = 1'b1;

    // Table-driven sequences on the 1-tick instance.
    foreach (vecs[i]) begin
      if (vecs[i].rst_first) pulse_reset();
      hold_clock = vecs[i].hold;
      edges(vecs[i].n);
      hold_clock = 1'b0;
      check($sformatf("vec%0d min", i), int'(minutes1), vecs[i].exp_min);
      check($sformatf("vec%0d sec", i), int'(seconds1), vecs[i].exp_sec);
      check_model($sformatf("vec%0d", i));
    end

    // Prescaler with 4 ticks per second, including a held partial second.
    pulse_reset();
    edges(3);
    check("pre 3 edges sec", int'(seconds4), 0);
    edges(1);
    check("pre 4th edge sec", int'(seconds4), 1);
    edges(2);
    hold_clock = 1'b1;
    edges(20);
    hold_clock = 1'b0;
    edges(1);
    check("pre partial sec", int'(seconds4), 1);
    edges(1);
    check("pre resume sec", int'(seconds4), 2);

    // Mid-second reset discards the partial second.
    pulse_reset();
    edges(30);
    check("mid 7s2 min", int'(minutes4), 0);
    check("mid 7s2 sec", int'(seconds4), 7);
    pulse_reset();
    edges(3);
    check("mid after 3 sec", int'(seconds4), 0);
    edges(1);
    check("mid after 4 min", int'(minutes4), 0);
    check("mid after 4 sec", int'(seconds4), 1);

    // Reset wins over hold.
    edges(8);
    hold_clock = 1'b1;
    reset = 1'b0;
    #1;
    check("rst vs hold t4 sec", int'(seconds4), 0);
    check("rst vs hold t1 sec", int'(seconds1), 0);
    edges(2);
    check("rst vs hold edge t1 sec", int'(seconds1), 0);
    reset = 1'b1;
    hold_clock = 1'b0;
    edges(1);
    check_model("after rst hold");

    // Randomized hold/reset traffic against the reference model.
    for (int c = 0; c < 9000; c++) begin
      hold_clock = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 3999) == 0) begin
        reset = 1'b0;
        #1;
        reset = 1'b1;
      end
      edges(1);
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
